// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback path: widths, the
// x0 address, requester ids and the arbiter priority-state encoding.
package regfile_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned AW        = 5;
    localparam int unsigned STARVE_CW = 4;   // wide enough for limits 1..15

    localparam logic [4:0] ZERO_REG   = 5'd0;

    localparam logic GRANT_EXEC = 1'b0;
    localparam logic GRANT_LOAD = 1'b1;

    typedef enum logic {
        PRIO1 = 1'b0,   // load-return data has priority
        PRIO0 = 1'b1    // exec result favoured after being starved
    } arb_state_e;

endpackage : regfile_pkg

// File: rtl/wb_age_counter.sv
// Saturating age counter for a writeback requester. Counts cycles in which the
// requester waits, clears on demand, and flags the edge at which the count
// is about to reach LIMIT so a consumer can switch priority on that same edge.
module wb_age_counter import regfile_pkg::*; #(
    parameter int unsigned LIMIT = 4,
    parameter int unsigned CW    = STARVE_CW
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic limit_hit
);

    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;

    // Next count: clear wins, otherwise count up until LIMIT and then hold.
    always_comb begin
        count_nxt_s = count_r;
        if (clr) begin
            count_nxt_s = {CW{1'b0}};
        end else if (inc && (count_r != CW'(LIMIT))) begin
            count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Age register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign limit_hit = (count_nxt_s == CW'(LIMIT));

endmodule : wb_age_counter

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the exec result
// (requester 0) and load-return data (requester 1). Loads win by default;
// an exec result that has waited STARVE_LIMIT cycles gets exactly one grant.
// The winner is registered onto the write port; x0 writes are accepted but
// never enable the port.
module regfile_wb_arbiter import regfile_pkg::*; #(
    parameter int unsigned XLEN         = regfile_pkg::XLEN,
    parameter int unsigned AW           = regfile_pkg::AW,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    input  logic [AW-1:0]   req0_addr,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [AW-1:0]   req1_addr,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    output logic            rf_we,
    output logic [AW-1:0]   rf_wa,
    output logic [XLEN-1:0] rf_wd,
    output logic            last_grant
);

    arb_state_e      state_r;
    arb_state_e      state_nxt_s;
    logic            req0_ready_s;
    logic            req1_ready_s;
    logic            hs0_s;
    logic            hs1_s;
    logic            starve_inc_s;
    logic            starve_clr_s;
    logic            starve_hit_s;
    logic [AW-1:0]   win_addr_s;
    logic [XLEN-1:0] win_data_s;
    logic            win_id_s;
    logic            rf_we_r;
    logic [AW-1:0]   rf_wa_r;
    logic [XLEN-1:0] rf_wd_r;
    logic            last_grant_r;

    // Ready generation: the favoured requester is accepted whenever valid, the
    // other only when the favoured one is idle. Nothing is accepted in reset.
    always_comb begin
        req0_ready_s = 1'b0;
        req1_ready_s = 1'b0;
        if (!rst_n) begin
            req0_ready_s = 1'b0;
            req1_ready_s = 1'b0;
        end else begin
            case (state_r)
                PRIO0: begin
                    req0_ready_s = req0_valid;
                    req1_ready_s = req1_valid & ~req0_valid;
                end
                PRIO1: begin
                    req1_ready_s = req1_valid;
                    req0_ready_s = req0_valid & ~req1_valid;
                end
                default: begin
                    req1_ready_s = req1_valid;
                    req0_ready_s = req0_valid & ~req1_valid;
                end
            endcase
        end
    end

    assign hs0_s        = req0_valid & req0_ready_s;
    assign hs1_s        = req1_valid & req1_ready_s;
    assign starve_inc_s = req0_valid & ~req0_ready_s;
    assign starve_clr_s = ~req0_valid | hs0_s;

    wb_age_counter #(
        .LIMIT (STARVE_LIMIT),
        .CW    (STARVE_CW)
    ) u_starve (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (starve_inc_s),
        .clr       (starve_clr_s),
        .limit_hit (starve_hit_s)
    );

    // Priority state: favour exec on the edge its wait reaches the limit and
    // drop back after its one grant (or once it stops asking).
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            PRIO1: begin
                if (starve_hit_s) begin
                    state_nxt_s = PRIO0;
                end else begin
                    state_nxt_s = PRIO1;
                end
            end
            PRIO0: begin
                if (hs0_s || !req0_valid) begin
                    state_nxt_s = PRIO1;
                end else begin
                    state_nxt_s = PRIO0;
                end
            end
            default: state_nxt_s = PRIO1;
        endcase
    end

    // Priority state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= PRIO1;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Winner select; at most one handshake exists per cycle.
    always_comb begin
        win_addr_s = req0_addr;
        win_data_s = req0_data;
        win_id_s   = GRANT_EXEC;
        if (hs1_s) begin
            win_addr_s = req1_addr;
            win_data_s = req1_data;
            win_id_s   = GRANT_LOAD;
        end else begin
            win_addr_s = req0_addr;
            win_data_s = req0_data;
            win_id_s   = GRANT_EXEC;
        end
    end

    // Write-port register: capture the winner one cycle after its handshake;
    // x0 targets are consumed without enabling the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_r      <= 1'b0;
            rf_wa_r      <= {AW{1'b0}};
            rf_wd_r      <= {XLEN{1'b0}};
            last_grant_r <= GRANT_EXEC;
        end else if (hs0_s || hs1_s) begin
            rf_we_r      <= (win_addr_s != AW'(ZERO_REG));
            rf_wa_r      <= win_addr_s;
            rf_wd_r      <= win_data_s;
            last_grant_r <= win_id_s;
        end else begin
            rf_we_r      <= 1'b0;
        end
    end

    assign req0_ready = req0_ready_s;
    assign req1_ready = req1_ready_s;
    assign rf_we      = rf_we_r;
    assign rf_wa      = rf_wa_r;
    assign rf_wd      = rf_wd_r;
    assign last_grant = last_grant_r;

endmodule : regfile_wb_arbiter
